uart_nic_arbiter: RTL and testbench
===================================

UART_NIC_ARBITER -- requirements
Module: uart_nic_arbiter

Interface
REQ-001 Parameter: CLKS_PER_FRAME, default 5208, minimum clk cycles between successive write_nic pulses (one 10-bit frame at 9600 baud / 50 MHz, x1/10 sim-friendly scale per build).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req_wr  input  2  per-requester transmit request, level, held until req_ack.
REQ-005 req_data0, req_data1  input  8 each  transmit byte, stable while req_wr[i]=1.
REQ-006 req_ack  output  2  one-cycle pulse: requester i's byte issued to NIC.
REQ-007 rx_valid  output  2  per-requester received byte available.
REQ-008 rx_data0, rx_data1  output  8 each  received byte, valid while rx_valid[i]=1.
REQ-009 rx_rd  input  2  one-cycle pop of requester i's rx holding register.
REQ-010 rx_ovf  output  2  sticky: byte dropped because holding register i full.
REQ-011 nic_data_in  output  8  byte to UART controller data_in.
REQ-012 nic_write  output  1  one-cycle pulse to controller write_nic.
REQ-013 nic_read  output  1  one-cycle pulse to controller read_nic.
REQ-014 nic_data_out  input  8  controller received byte.
REQ-015 nic_read_i  input  1  controller receive interrupt, level, high while byte pending.

Function
REQ-016 TX FSM states T_IDLE, T_ISSUE, T_GAP; reset state T_IDLE.
REQ-017 T_IDLE: if req_wr nonzero, grant one requester round-robin (requester not granted last wins tie; after reset port 0 has priority), latch its byte, go T_ISSUE next cycle.
REQ-018 T_ISSUE (one cycle): nic_write=1, nic_data_in=latched byte, req_ack[grant]=1, load gap counter with CLKS_PER_FRAME-1, go T_GAP.
REQ-019 T_GAP: decrement counter each cycle; at 0 go T_IDLE; requests during T_GAP wait, never dropped.
REQ-020 Issue latency from req_wr rise in T_IDLE to nic_write: 2 cycles; minimum spacing between nic_write pulses: CLKS_PER_FRAME+1 cycles.
REQ-021 Owner register = last granted requester (reset 0); updated in T_ISSUE.
REQ-022 RX FSM states R_IDLE, R_READ, R_WAIT; reset R_IDLE.
REQ-023 R_IDLE: nic_read_i=1 -> R_READ.  R_READ (one cycle): nic_read=1, capture nic_data_out, route to owner's holding register, go R_WAIT.  R_WAIT: nic_read_i=0 -> R_IDLE.
REQ-024 Routing to a full holding register (rx_valid[i]=1 and no rx_rd[i] same cycle): byte dropped, rx_ovf[i] set; existing byte kept.
REQ-025 rx_rd[i] and new capture same cycle: new byte loaded, rx_valid[i] stays 1, no overflow.
REQ-026 rx_rd[i] with rx_valid[i]=0: ignored.
REQ-027 rx_ovf[i] clears only on reset.
REQ-028 Owner change during R_READ takes effect for the next byte only.

Reset
REQ-029 On rst low, immediately: all outputs 0, FSMs to T_IDLE/R_IDLE, counter 0, owner 0, holding registers invalid, round-robin pointer to port 0; reset mid-T_GAP abandons the gap, mid-R_READ discards the byte.

Configuration
REQ-030 Macro UART_NIC_ARBITER_RX_BROADCAST_EN defined: every received byte routed to both holding registers, overflow evaluated per port independently; undefined: owner-only routing per REQ-023.

Structure
REQ-031 Package uart_arb_pkg holds tx_state_t, rx_state_t enums and default CLKS_PER_FRAME constant.
REQ-032 Sub-module rr_arbiter2: 2-input round-robin grant with last-grant pointer, used by TX FSM.

Verification (CLKS_PER_FRAME=8)
REQ-033 req_wr=01, req_data0=8'hA5 -> nic_write pulse 2 cycles later with nic_data_in=A5, req_ack=01 same cycle.
REQ-034 req_wr=11 held -> grants alternate 0,1,0,1; nic_write pulses exactly 9 cycles apart.
REQ-035 Port 1 sends, then nic_read_i=1 with nic_data_out=8'h3C -> one nic_read pulse, rx_valid=10, rx_data1=3C; rx_valid[0] stays 0.
REQ-036 Two received bytes 11,22 without rx_rd -> rx_data=11 retained, rx_ovf[owner]=1; broadcast build: both ports hold 11, both ovf set.
REQ-037 rst low during T_GAP and with rx_valid=01 -> all outputs 0 same cycle; after release, pending req_wr issued in 2 cycles.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// Shared types and defaults for the UART NIC arbiter: TX/RX state encodings and frame spacing.
package uart_arb_pkg;

  localparam int CLKS_PER_FRAME_DEFAULT = 5208;

  typedef enum logic [1:0] {
    T_IDLE,
    T_ISSUE,
    T_GAP
  } tx_state_t;

  typedef enum logic [1:0] {
    R_IDLE,
    R_READ,
    R_WAIT
  } rx_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter; on a tie the port not granted last wins, port 0 first after reset.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       gnt_valid,
  output logic       gnt_idx
);

  logic prio;

  always_comb begin
    gnt_valid = |req;
    gnt_idx   = 1'b0;
    if (req == 2'b11) begin
      gnt_idx = prio;
    end else if (req[1]) begin
      gnt_idx = 1'b1;
    end
  end

  // prio names the port that wins the next tie, i.e. the one not granted last
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio <= 1'b0;
    end else if (advance && gnt_valid) begin
      prio <= ~gnt_idx;
    end
  end

endmodule

// File: rtl/uart_nic_arbiter.sv
// Shares one UART NIC between two requesters: paced TX with round-robin grant, RX routed to the owner.
// Define UART_NIC_ARBITER_RX_BROADCAST_EN to copy every received byte to both holding registers.
module uart_nic_arbiter
  import uart_arb_pkg::*;
#(
  parameter int CLKS_PER_FRAME = CLKS_PER_FRAME_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_wr,
  input  logic [7:0] req_data0,
  input  logic [7:0] req_data1,
  output logic [1:0] req_ack,
  output logic [1:0] rx_valid,
  output logic [7:0] rx_data0,
  output logic [7:0] rx_data1,
  input  logic [1:0] rx_rd,
  output logic [1:0] rx_ovf,
  output logic [7:0] nic_data_in,
  output logic       nic_write,
  output logic       nic_read,
  input  logic [7:0] nic_data_out,
  input  logic       nic_read_i
);

  localparam int CW = (CLKS_PER_FRAME > 2) ? $clog2(CLKS_PER_FRAME) : 1;

  tx_state_t     tx_state;
  rx_state_t     rx_state;
  logic [CW-1:0] gap_cnt;
  logic          owner;
  logic          grant_idx;
  logic [7:0]    tx_byte;
  logic          arb_valid;
  logic          arb_idx;
  logic [1:0]    route;
  logic [7:0]    hold_data [2];

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_wr),
    .advance   (tx_state == T_IDLE),
    .gnt_valid (arb_valid),
    .gnt_idx   (arb_idx)
  );

  // Gap exits when the counter would reach zero, so issues are CLKS_PER_FRAME+1 cycles apart
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state    <= T_IDLE;
      gap_cnt     <= '0;
      owner       <= 1'b0;
      grant_idx   <= 1'b0;
      tx_byte     <= '0;
      nic_write   <= 1'b0;
      nic_data_in <= '0;
      req_ack     <= '0;
    end else begin
      nic_write <= 1'b0;
      req_ack   <= '0;
      case (tx_state)
        T_IDLE: begin
          if (arb_valid) begin
            grant_idx <= arb_idx;
            tx_byte   <= arb_idx ? req_data1 : req_data0;
            tx_state  <= T_ISSUE;
          end
        end
        T_ISSUE: begin
          nic_write   <= 1'b1;
          nic_data_in <= tx_byte;
          req_ack     <= grant_idx ? 2'b10 : 2'b01;
          owner       <= grant_idx;
          gap_cnt     <= CW'(CLKS_PER_FRAME - 1);
          tx_state    <= T_GAP;
        end
        T_GAP: begin
          if (gap_cnt <= CW'(1)) begin
            gap_cnt  <= '0;
            tx_state <= T_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: tx_state <= T_IDLE;
      endcase
    end
  end

`ifdef UART_NIC_ARBITER_RX_BROADCAST_EN
  assign route = 2'b11;
`else
  assign route = owner ? 2'b10 : 2'b01;
`endif

  // A full register keeps its byte and flags overflow unless it is popped in the capture cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state <= R_IDLE;
      nic_read <= 1'b0;
      rx_valid <= '0;
      rx_ovf   <= '0;
      for (int i = 0; i < 2; i++) begin
        hold_data[i] <= '0;
      end
    end else begin
      nic_read <= 1'b0;
      case (rx_state)
        R_IDLE: begin
          if (nic_read_i) begin
            rx_state <= R_READ;
          end
        end
        R_READ: begin
          nic_read <= 1'b1;
          rx_state <= R_WAIT;
        end
        R_WAIT: begin
          if (!nic_read_i) begin
            rx_state <= R_IDLE;
          end
        end
        default: rx_state <= R_IDLE;
      endcase
      for (int i = 0; i < 2; i++) begin
        if ((rx_state == R_READ) && route[i]) begin
          if (rx_valid[i] && !rx_rd[i]) begin
            rx_ovf[i] <= 1'b1;
          end else begin
            hold_data[i] <= nic_data_out;
            rx_valid[i]  <= 1'b1;
          end
        end else if (rx_rd[i]) begin
          rx_valid[i] <= 1'b0;
        end
      end
    end
  end

  assign rx_data0 = hold_data[0];
  assign rx_data1 = hold_data[1];

endmodule

// File: tb/tb_uart_nic_arbiter.sv
// Directed self-checking bench for uart_nic_arbiter with CLKS_PER_FRAME=8.
// Honors UART_NIC_ARBITER_RX_BROADCAST_EN when choosing expected RX routing.
module tb_uart_nic_arbiter;

`ifdef UART_NIC_ARBITER_RX_BROADCAST_EN
  localparam bit BCAST = 1'b1;
`else
  localparam bit BCAST = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic [1:0] req_wr;
  logic [7:0] req_data0;
  logic [7:0] req_data1;
  logic [1:0] req_ack;
  logic [1:0] rx_valid;
  logic [7:0] rx_data0;
  logic [7:0] rx_data1;
  logic [1:0] rx_rd;
  logic [1:0] rx_ovf;
  logic [7:0] nic_data_in;
  logic       nic_write;
  logic       nic_read;
  logic [7:0] nic_data_out;
  logic       nic_read_i;

  int n_cmp;
  int n_err;

  uart_nic_arbiter #(.CLKS_PER_FRAME(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_wr       (req_wr),
    .req_data0    (req_data0),
    .req_data1    (req_data1),
    .req_ack      (req_ack),
    .rx_valid     (rx_valid),
    .rx_data0     (rx_data0),
    .rx_data1     (rx_data1),
    .rx_rd        (rx_rd),
    .rx_ovf       (rx_ovf),
    .nic_data_in  (nic_data_in),
    .nic_write    (nic_write),
    .nic_read     (nic_read),
    .nic_data_out (nic_data_out),
    .nic_read_i   (nic_read_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents one byte on the NIC receive side; rd is applied in the capture cycle
  task automatic rx_byte(input logic [7:0] b, input logic [1:0] rd);
    nic_read_i   = 1'b1;
    nic_data_out = b;
    tick();
    rx_rd = rd;
    tick();
    rx_rd = 2'b00;
    check_output("nic_read_pulse", {15'd0, nic_read}, 16'd1);
    nic_read_i = 1'b0;
    tick();
    check_output("nic_read_end", {15'd0, nic_read}, 16'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_ack"},    {14'd0, req_ack},   16'd0);
    check_output({tag, "_valid"},  {14'd0, rx_valid},  16'd0);
    check_output({tag, "_ovf"},    {14'd0, rx_ovf},    16'd0);
    check_output({tag, "_rxd"},    {rx_data1, rx_data0}, 16'd0);
    check_output({tag, "_nicd"},   {8'd0, nic_data_in}, 16'd0);
    check_output({tag, "_wr_rd"},  {14'd0, nic_write, nic_read}, 16'd0);
  endtask

  int          pulse_cyc [4];
  logic [1:0]  pulse_ack [4];
  logic [7:0]  pulse_dat [4];
  int          n_pulse;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    req_wr = 2'b00;
    req_data0 = 8'h00;
    req_data1 = 8'h00;
    rx_rd = 2'b00;
    nic_data_out = 8'h00;
    nic_read_i = 1'b0;

    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    // Single request from port 0: issue two cycles later
    req_wr = 2'b01;
    req_data0 = 8'hA5;
    tick();
    check_output("tx0_latency", {15'd0, nic_write}, 16'd0);
    tick();
    check_output("tx0_write", {15'd0, nic_write}, 16'd1);
    check_output("tx0_data", {8'd0, nic_data_in}, 16'h00A5);
    check_output("tx0_ack", {14'd0, req_ack}, 16'h0001);
    req_wr = 2'b00;
    tick();
    check_output("tx0_pulse_end", {14'd0, req_ack, 1'b0, nic_write} , 16'd0);
    repeat (10) tick();

    // Port 1 sends and becomes owner, then a byte arrives
    req_wr = 2'b10;
    req_data1 = 8'h77;
    tick();
    tick();
    check_output("tx1_ack", {14'd0, req_ack}, 16'h0002);
    check_output("tx1_data", {8'd0, nic_data_in}, 16'h0077);
    req_wr = 2'b00;
    rx_byte(8'h3C, 2'b00);
    check_output("rx1_valid", {14'd0, rx_valid}, BCAST ? 16'h0003 : 16'h0002);
    check_output("rx1_data1", {8'd0, rx_data1}, 16'h003C);
    check_output("rx1_data0", {8'd0, rx_data0}, BCAST ? 16'h003C : 16'h0000);

    // Pop and capture in the same cycle: new byte loaded, no overflow
    rx_byte(8'h44, BCAST ? 2'b11 : 2'b10);
    check_output("rdcap_valid", {14'd0, rx_valid}, BCAST ? 16'h0003 : 16'h0002);
    check_output("rdcap_data1", {8'd0, rx_data1}, 16'h0044);
    check_output("rdcap_ovf", {14'd0, rx_ovf}, 16'd0);

    rx_rd = 2'b11;
    tick();
    rx_rd = 2'b00;
    check_output("pop_valid", {14'd0, rx_valid}, 16'd0);
    rx_rd = 2'b11;
    tick();
    rx_rd = 2'b00;
    check_output("pop_empty_valid", {14'd0, rx_valid}, 16'd0);
    check_output("pop_empty_ovf", {14'd0, rx_ovf}, 16'd0);
    repeat (6) tick();

    // Both ports held: grants alternate starting at port 0, pulses 9 cycles apart
    req_wr = 2'b11;
    req_data0 = 8'h10;
    req_data1 = 8'h21;
    n_pulse = 0;
    for (int cyc = 1; cyc <= 45 && n_pulse < 4; cyc++) begin
      tick();
      if (nic_write) begin
        pulse_cyc[n_pulse] = cyc;
        pulse_ack[n_pulse] = req_ack;
        pulse_dat[n_pulse] = nic_data_in;
        n_pulse++;
        if (n_pulse == 4) req_wr = 2'b00;
      end
    end
    req_wr = 2'b00;
    check_output("rr_pulse_count", 16'(n_pulse), 16'd4);
    if (n_pulse == 4) begin
      check_output("rr_first_cyc", 16'(pulse_cyc[0]), 16'd2);
      for (int k = 0; k < 4; k++) begin
        check_output($sformatf("rr_ack%0d", k), {14'd0, pulse_ack[k]}, (k % 2 == 0) ? 16'h0001 : 16'h0002);
        check_output($sformatf("rr_data%0d", k), {8'd0, pulse_dat[k]}, (k % 2 == 0) ? 16'h0010 : 16'h0021);
      end
      for (int k = 1; k < 4; k++) begin
        check_output($sformatf("rr_space%0d", k), 16'(pulse_cyc[k] - pulse_cyc[k-1]), 16'd9);
      end
    end
    repeat (12) tick();

    // Owner is port 1: two bytes without a pop, second one overflows
    rx_byte(8'h11, 2'b00);
    check_output("ovf_first_valid", {14'd0, rx_valid}, BCAST ? 16'h0003 : 16'h0002);
    rx_byte(8'h22, 2'b00);
    check_output("ovf_data1", {8'd0, rx_data1}, 16'h0011);
    check_output("ovf_data0", {8'd0, rx_data0}, BCAST ? 16'h0011 : 16'h0000);
    check_output("ovf_flags", {14'd0, rx_ovf}, BCAST ? 16'h0003 : 16'h0002);
    check_output("ovf_valid", {14'd0, rx_valid}, BCAST ? 16'h0003 : 16'h0002);

    // Port 0 sends (owner 0), a byte lands in port 0, then reset mid-gap
    req_wr = 2'b01;
    req_data0 = 8'h5A;
    tick();
    tick();
    check_output("rst_pre_write", {15'd0, nic_write}, 16'd1);
    check_output("rst_pre_data", {8'd0, nic_data_in}, 16'h005A);
    req_wr = 2'b00;
    rx_rd = 2'b11;
    tick();
    rx_rd = 2'b00;
    rx_byte(8'h66, 2'b00);
    check_output("rst_pre_valid", {14'd0, rx_valid}, BCAST ? 16'h0003 : 16'h0001);
    check_output("rst_pre_data0", {8'd0, rx_data0}, 16'h0066);
    req_wr = 2'b10;
    req_data1 = 8'hC3;
    #1 rst = 1'b0;
    #1 check_all_zero("async_rst");
    tick();
    rst = 1'b1;
    tick();
    check_output("post_rst_latency", {15'd0, nic_write}, 16'd0);
    tick();
    check_output("post_rst_write", {15'd0, nic_write}, 16'd1);
    check_output("post_rst_ack", {14'd0, req_ack}, 16'h0002);
    check_output("post_rst_data", {8'd0, nic_data_in}, 16'h00C3);
    req_wr = 2'b00;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
